// File: rtl/spartan_cpu_pkg.sv
// Shared widths, reset PC and the fetch-buffer entry type for the fetch path.
package spartan_cpu_pkg;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0010;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer; flush beats enqueue/dequeue, head is visible combinationally.
module fetch_fifo
   import spartan_cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter type entry_t = fetch_entry_t,
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enq,
   input  logic          deq,
   input  logic          flush,
   input  entry_t        enq_data,
   output entry_t        head,
   output logic [CW-1:0] count
);
   localparam int PW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (enq && !flush)
         mem[wr_ptr] <= enq_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= ptr_inc(wr_ptr);
         if (deq) rd_ptr <= ptr_inc(rd_ptr);
         if (enq && !deq)      count <= count + 1'b1;
         else if (!enq && deq) count <= count - 1'b1;
      end
   end

   assign head = mem[rd_ptr];

   // The issuer's credit check makes overflow impossible.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(enq && !deq && !flush && (count == CW'(DEPTH))));
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one read per cycle when a buffer slot is guaranteed, captures
// the word from the shared bus a cycle later, and drops everything on redirect.
module instr_fetch
   import spartan_cpu_pkg::*;
#(
   parameter int ADDR_W = spartan_cpu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(spartan_cpu_pkg::RESET_PC),
   parameter int DEPTH = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_busy,
   output logic              i_read,
   output logic [ADDR_W-1:0] i_addr,
   output logic              i_push,
   input  logic [WORD_W-1:0] bus_in,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] issue_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [CW:0]       used;
   logic              deq;
   logic              issue;
   entry_t            head;
   entry_t            push_entry;

   assign instr_valid = (count != '0);
   assign deq         = instr_valid & instr_ready & ~redirect;

   // Slots already claimed after this cycle: buffered words plus the one on the bus.
   assign used  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
   assign issue = rst_n & ~redirect & ~mem_busy & (used < (CW+1)'(DEPTH));

   assign i_read = issue;
   assign i_addr = pc;
   assign i_push = inflight;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         issue_pc <= '0;
         inflight <= 1'b0;
      end else if (redirect) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc       <= pc + 1'b1;
            issue_pc <= pc;
         end
      end
   end

   assign push_entry = '{instr: bus_in, pc: issue_pc};

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .enq      (inflight),
      .deq      (deq),
      .flush    (redirect),
      .enq_data (push_entry),
      .head     (head),
      .count    (count)
   );

   assign instr    = instr_valid ? head.instr : '0;
   assign instr_pc = instr_valid ? head.pc    : '0;

   assert property (@(posedge clk) disable iff (!rst_n) !(mem_busy && i_read));
endmodule

// File: tb/tb_instr_fetch.sv
// Fetch-stage bench: behavioural memory on the bus, program-order scoreboard of expected PCs.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_busy = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        instr_ready = 1'b0;
   logic        i_read;
   logic [15:0] i_addr;
   logic        i_push;
   logic [15:0] bus_in;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic        pend;
   logic [15:0] pend_addr;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_busy    (mem_busy),
      .i_read      (i_read),
      .i_addr      (i_addr),
      .i_push      (i_push),
      .bus_in      (bus_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0010) return 16'hBF01;
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // Memory: a read strobe seen at an edge drives the word on the bus for the next cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         pend_addr <= '0;
      end else begin
         pend      <= i_read;
         pend_addr <= i_addr;
      end
   end
   assign bus_in = pend ? mem_word(pend_addr) : ~mem_word(pend_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Program order restarts at the given PC after reset or redirect.
   task automatic restart(input logic [15:0] start);
      exp_q.delete();
      for (int i = 0; i < 1024; i++) exp_q.push_back(start + 16'(i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // Monitor: bus protocol every cycle, scoreboard on every accepted instruction.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("i_push_follows_read", 32'(i_push), 32'(pend));
         chk("busy_blocks_read", 32'(i_read & mem_busy), 32'd0);
         if (instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty: got pc %h want none", instr_pc);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               chk("instr_pc", 32'(instr_pc), 32'(e));
               chk("instr", 32'(instr), 32'(mem_word(e)));
            end
         end
      end
   end

   initial begin
      int since;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_i_read", 32'(i_read), 32'd0);
      chk("rst_i_push", 32'(i_push), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);

      // Reset release and backpressure with decode stalled.
      @(posedge clk);
      #1 rst_n = 1'b1;
      restart(16'h0010);
      look();
      chk("t1_read", 32'(i_read), 32'd1);
      chk("t1_addr", 32'(i_addr), 32'h0010);
      chk("t1_push0", 32'(i_push), 32'd0);
      tick(); look();
      chk("t3_read2", 32'(i_read), 32'd1);
      chk("t3_addr2", 32'(i_addr), 32'h0011);
      chk("t1_push", 32'(i_push), 32'd1);
      chk("t1_not_valid_yet", 32'(instr_valid), 32'd0);
      tick(); look();
      chk("t3_stop", 32'(i_read), 32'd0);
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr_pc", 32'(instr_pc), 32'h0010);
      chk("t1_instr", 32'(instr), 32'hBF01);
      tick(); look();
      chk("t3_hold", 32'(i_read), 32'd0);
      chk("t3_head", 32'(instr_pc), 32'h0010);

      // Stream: reads resume at 0x0012 and never drop.
      tick(); instr_ready = 1'b1; look();
      chk("t3_resume", 32'(i_read), 32'd1);
      chk("t3_resume_addr", 32'(i_addr), 32'h0012);
      for (int k = 1; k <= 4; k++) begin
         tick(); look();
         chk("t2_stream_read", 32'(i_read), 32'd1);
         chk("t2_stream_addr", 32'(i_addr), 32'h0012 + 32'(k));
      end

      // Data side owns memory for three cycles.
      tick(); mem_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         look();
         chk("t4_busy_no_read", 32'(i_read), 32'd0);
         if (k < 2) tick();
      end
      tick(); mem_busy = 1'b0; look();
      chk("t4_resume_read", 32'(i_read), 32'd1);
      chk("t4_resume_addr", 32'(i_addr), 32'h0017);

      // Redirect right after an issue.
      tick(); redirect = 1'b1; redirect_pc = 16'h00B1; restart(16'h00B1); look();
      chk("t5_no_read", 32'(i_read), 32'd0);
      tick(); redirect = 1'b0; look();
      chk("t5_push_dropped", 32'(i_push), 32'd0);
      chk("t5_flushed", 32'(instr_valid), 32'd0);
      chk("t5_addr", 32'(i_addr), 32'h00B1);
      tick(); tick(); look();
      chk("t5_valid", 32'(instr_valid), 32'd1);
      chk("t5_pc", 32'(instr_pc), 32'h00B1);

      // PC wrap.
      tick(); redirect = 1'b1; redirect_pc = 16'hFFFF; restart(16'hFFFF);
      tick(); redirect = 1'b0; look();
      chk("t6_addr_ffff", 32'(i_addr), 32'hFFFF);
      tick(); look();
      chk("t6_wrap_read", 32'(i_read), 32'd1);
      chk("t6_addr_0000", 32'(i_addr), 32'h0000);

      // Asynchronous reset pulse mid-stream.
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_arst_read", 32'(i_read), 32'd0);
      chk("t6_arst_push", 32'(i_push), 32'd0);
      chk("t6_arst_valid", 32'(instr_valid), 32'd0);
      chk("t6_arst_instr", 32'(instr), 32'd0);
      chk("t6_arst_pc", 32'(instr_pc), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      restart(16'h0010);
      look();
      chk("t6_restart_addr", 32'(i_addr), 32'h0010);
      chk("t6_restart_read", 32'(i_read), 32'd1);

      // Random traffic.
      since = 0;
      for (int c = 0; c < 1500; c++) begin
         tick();
         instr_ready = ($urandom_range(0, 3) != 0);
         mem_busy    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 29) == 0 || since >= 200) begin
            redirect    = 1'b1;
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                      : 16'($urandom());
            restart(redirect_pc);
            since = 0;
         end else begin
            redirect = 1'b0;
            since++;
         end
      end
      tick();
      redirect = 1'b0;
      look();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
